// File: rtl/pb_arbiter.sv
// First-press arbiter for N player push-buttons: synchronise, debounce, edge-detect, latch the round winner.
// Define TIE_PRIORITY_EN to resolve simultaneous presses by lowest index instead of flagging a tie.
module pb_arbiter #(
    parameter int N_PLAYERS  = 2,
    parameter int DEB_CYCLES = 4,
    parameter int IDX_W      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_PLAYERS-1:0] pb,
    input  logic                 clr,
    output logic                 push,
    output logic                 tie,
    output logic [N_PLAYERS-1:0] winner_oh,
    output logic [IDX_W-1:0]     winner_idx,
    output logic                 armed
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_REARM,
        S_ARMED,
        S_DECIDED
    } state_e;

    logic [N_PLAYERS-1:0] sync1_q, sync2_q;
    logic [N_PLAYERS-1:0] deb_q, deb_d;
    logic [N_PLAYERS-1:0] evt_q, evt_d;
    logic [CNT_W-1:0]     cnt_q [N_PLAYERS];
    logic [CNT_W-1:0]     cnt_d [N_PLAYERS];

    state_e               state_q, state_d;
    logic                 push_q, push_d;
    logic                 tie_q, tie_d;
    logic [N_PLAYERS-1:0] oh_q, oh_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic [N_PLAYERS-1:0] low_oh;
    logic [IDX_W-1:0]     low_idx;

    // A level flips only after DEB_CYCLES consecutive disagreeing samples; the flip to 1 is the press event.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        deb_d = deb_q;
        evt_d = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                    evt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Scan downward so the lowest set event index is the one that sticks.
    always_comb begin
        low_idx = '0;
        low_oh  = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (evt_q[i]) begin
                low_idx   = IDX_W'(i);
                low_oh    = '0;
                low_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        push_d  = 1'b0;
        tie_d   = tie_q;
        oh_d    = oh_q;
        idx_d   = idx_q;
        case (state_q)
            S_REARM: begin
                // Wait for every button to be released so a press held across clr cannot win.
                if (deb_q == '0) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (clr) begin
                    state_d = S_REARM;
                end else if (|evt_q) begin
                    push_d  = 1'b1;
                    idx_d   = low_idx;
                    state_d = S_DECIDED;
`ifdef TIE_PRIORITY_EN
                    oh_d    = low_oh;
                    tie_d   = 1'b0;
`else
                    oh_d    = evt_q;
                    tie_d   = (evt_q != low_oh);
`endif
                end
            end
            S_DECIDED: begin
                if (clr) begin
                    oh_d    = '0;
                    idx_d   = '0;
                    tie_d   = 1'b0;
                    state_d = S_REARM;
                end
            end
            default: state_d = S_REARM;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            evt_q   <= '0;
            // NOTE: the counter array is a handful of flops, not RAM, so resetting it is cheap and safe.
            for (int i = 0; i < N_PLAYERS; i++) cnt_q[i] <= '0;
            state_q <= S_REARM;
            push_q  <= 1'b0;
            tie_q   <= 1'b0;
            oh_q    <= '0;
            idx_q   <= '0;
        end else begin
            sync1_q <= pb;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            evt_q   <= evt_d;
            for (int i = 0; i < N_PLAYERS; i++) cnt_q[i] <= cnt_d[i];
            state_q <= state_d;
            push_q  <= push_d;
            tie_q   <= tie_d;
            oh_q    <= oh_d;
            idx_q   <= idx_d;
        end
    end

    assign push       = push_q;
    assign tie        = tie_q;
    assign winner_oh  = oh_q;
    assign winner_idx = idx_q;
    assign armed      = (state_q == S_ARMED);

endmodule

// File: tb/tb_pb_arbiter.sv
// Directed bench for pb_arbiter: a 2-player instance for round behaviour and a 4-player instance for wide index and reset.
module tb_pb_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pb2;
    logic       clr2;
    logic       push2, tie2, armed2;
    logic [1:0] oh2;
    logic [0:0] idx2;

    logic [3:0] pb4;
    logic       clr4;
    logic       push4, tie4, armed4;
    logic [3:0] oh4;
    logic [1:0] idx4;

    int n_checks = 0;
    int n_errors = 0;
    int push2_cnt = 0;
    logic push2_prev = 1'b0;

    always #5 clk = ~clk;

    pb_arbiter #(.N_PLAYERS(2), .DEB_CYCLES(4), .IDX_W(1)) u2 (
        .clk(clk), .rst(rst), .pb(pb2), .clr(clr2),
        .push(push2), .tie(tie2), .winner_oh(oh2), .winner_idx(idx2), .armed(armed2)
    );

    pb_arbiter #(.N_PLAYERS(4), .DEB_CYCLES(4), .IDX_W(2)) u4 (
        .clk(clk), .rst(rst), .pb(pb4), .clr(clr4),
        .push(push4), .tie(tie4), .winner_oh(oh4), .winner_idx(idx4), .armed(armed4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes are counted and must never appear on two consecutive cycles.
    always @(negedge clk) begin
        if (push2) begin
            push2_cnt++;
            check("push_back_to_back", {31'b0, push2_prev}, 32'd0);
        end
        push2_prev = push2;
    end

    // Press pattern p; push must appear exactly on the 7th edge after the first sampling edge.
    task automatic round2(input string tag, input logic [1:0] p,
                          input logic [1:0] e_oh, input logic e_idx, input logic e_tie);
        pb2 = p;
        repeat (6) tick();
        check({tag, "_push_early"}, push2, 1'b0);
        tick();
        check({tag, "_push"}, push2, 1'b1);
        check({tag, "_oh"}, oh2, e_oh);
        check({tag, "_idx"}, idx2, e_idx);
        check({tag, "_tie"}, tie2, e_tie);
        check({tag, "_armed"}, armed2, 1'b0);
        tick();
        check({tag, "_push_1cyc"}, push2, 1'b0);
        check({tag, "_oh_hold"}, oh2, e_oh);
    endtask

    task automatic clear_release2(input string tag);
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        check({tag, "_clr_oh"}, oh2, 2'b00);
        check({tag, "_clr_idx"}, idx2, 1'b0);
        check({tag, "_clr_tie"}, tie2, 1'b0);
        pb2 = 2'b00;
        repeat (10) tick();
        check({tag, "_rearmed"}, armed2, 1'b1);
    endtask

    initial begin
        int base;
        rst  = 1'b0;
        pb2  = 2'b00;
        clr2 = 1'b0;
        pb4  = 4'b0000;
        clr4 = 1'b0;
        #12;
        check("rst_armed", armed2, 1'b0);
        check("rst_push", push2, 1'b0);
        check("rst_oh", oh2, 2'b00);
        check("rst_tie", tie2, 1'b0);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        check("armed_after_rst", armed2, 1'b1);
        check("armed4_after_rst", armed4, 1'b1);

        // Single press on channel 0.
        round2("single0", 2'b01, 2'b01, 1'b0, 1'b0);
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        check("held_clr_oh", oh2, 2'b00);
        repeat (3) tick();
        check("held_stays_rearm", armed2, 1'b0);
        pb2 = 2'b00;
        repeat (10) tick();
        check("release_rearms", armed2, 1'b1);

        // Simultaneous press.
`ifdef TIE_PRIORITY_EN
        round2("tie", 2'b11, 2'b01, 1'b0, 1'b0);
`else
        round2("tie", 2'b11, 2'b11, 1'b0, 1'b1);
`endif
        clear_release2("tie");

        // Channel 1 wins; a later channel 0 press is ignored.
        round2("win1", 2'b10, 2'b10, 1'b1, 1'b0);
        base = push2_cnt;
        pb2 = 2'b11;
        repeat (10) tick();
        check("decided_no_push", push2_cnt - base, 0);
        check("decided_oh_held", oh2, 2'b10);
        check("decided_idx_held", idx2, 1'b1);
        pb2 = 2'b10;
        repeat (10) tick();
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        repeat (10) tick();
        check("pb1_held_rearm", armed2, 1'b0);
        pb2 = 2'b00;
        repeat (10) tick();
        check("pb1_release_armed", armed2, 1'b1);
        round2("new0", 2'b01, 2'b01, 1'b0, 1'b0);
        clear_release2("new0");

        // Bounce shorter than the debounce window.
        base = push2_cnt;
        pb2 = 2'b01;
        repeat (2) tick();
        pb2 = 2'b00;
        repeat (12) tick();
        check("bounce_no_push", push2_cnt - base, 0);
        check("bounce_oh", oh2, 2'b00);
        check("bounce_armed", armed2, 1'b1);

        // clr coincides with the press event: clr wins.
        base = push2_cnt;
        pb2 = 2'b01;
        repeat (6) tick();
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        check("clr_evt_push", push2, 1'b0);
        check("clr_evt_armed", armed2, 1'b0);
        check("clr_evt_oh", oh2, 2'b00);
        repeat (3) tick();
        check("clr_evt_no_push", push2_cnt - base, 0);
        pb2 = 2'b00;
        repeat (10) tick();
        check("clr_evt_rearmed", armed2, 1'b1);

        // Four-player instance: highest channel wins, then reset mid-round.
        pb4 = 4'b1000;
        repeat (6) tick();
        check("n4_push_early", push4, 1'b0);
        tick();
        check("n4_push", push4, 1'b1);
        check("n4_idx", idx4, 2'd3);
        check("n4_oh", oh4, 4'b1000);
        check("n4_tie", tie4, 1'b0);
        tick();
        check("n4_oh_hold", oh4, 4'b1000);
        rst = 1'b0;
        #2;
        check("n4_rst_oh", oh4, 4'b0000);
        check("n4_rst_idx", idx4, 2'd0);
        check("n4_rst_armed", armed4, 1'b0);
        check("n4_rst_push", push4, 1'b0);
        check("n2_rst_armed", armed2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pb_arbiter.md
Name: pb_arbiter

Overview:
- Parametrised first-press arbiter for Tug-of-War player push-buttons; generalises the 2-player combinational latch pair to N_PLAYERS channels.
- Each raw button is synchronised, debounced and edge-detected. A round FSM latches the first press (or a simultaneous tie) and holds it until `clr`.
- Sits between the board buttons and the game/score controller. The controller consumes `push`, `winner_*` and `tie`.

Parameters:
- N_PLAYERS, 2, number of button channels (2..16)
- DEB_CYCLES, 4, consecutive stable samples needed to change a debounced level (>=1)
- IDX_W, 1, width of winner_idx; must be >= ceil(log2(N_PLAYERS)), minimum 1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- pb  in  N_PLAYERS  raw asynchronous buttons, active-high
- clr  in  1  synchronous round clear, active-high
- push  out  1  one-cycle pulse when a round is decided
- tie  out  1  held high while the decided round was a simultaneous press
- winner_oh  out  N_PLAYERS  one-hot (or multi-hot on tie) winners, held until clr
- winner_idx  out  IDX_W  index of the winner; lowest set index on tie
- armed  out  1  high while in ARMED state

Behaviour:
- Reset (rst=0, async): FSM=REARM; all outputs 0; sync flops, debounced levels and counters cleared to 0.
- Per-channel front end:
  - 2-flop synchroniser.
  - Debounce counter: counts while the synced level differs from the debounced level, and clears when they match. At DEB_CYCLES the debounced level flips and the counter clears.
  - Press event = debounced rising edge, one cycle wide.
- Latency: pb held high from edge t gives `push` high in the cycle after edge t+DEB_CYCLES+2, i.e. DEB_CYCLES+3 clocks total.
- REARM: if all debounced levels are 0, go to ARMED next cycle; otherwise stay. Press events are discarded. Prevents a button held across clr from winning.
- ARMED (armed=1):
  - Event vector e=0: stay.
  - popcount(e)=1: register winner_oh=e and winner_idx=index(e); pulse push; tie=0; go to DECIDED.
  - popcount(e)>=2: winner_oh=e; winner_idx=lowest set index; tie=1; pulse push; go to DECIDED.
  - clr=1: go to REARM; clr wins over any same-cycle event, which is discarded with no push.
- DECIDED: all further events are ignored; outputs held. clr=1 clears winner_oh, winner_idx and tie to 0 on the next edge and goes to REARM.
- push is never high in two consecutive cycles. Exactly one push per round.
- Release bounce shorter than DEB_CYCLES produces no event. A bounce that reaches DEB_CYCLES is a legitimate release, and the next press is a new event.
- Reset mid-round: immediate return to reset values; the round is lost.

Optional Feature:
- Macro TIE_PRIORITY_EN.
- Defined: simultaneous events resolve by fixed priority. The lowest index wins; winner_oh is one-hot for that index only; tie stays 0 permanently.
- Undefined: tie behaviour as specified above.

Test Plan:
- N=2, DEB=4: after reset both released → armed=1 at cycle 2. pb=01 held → push pulse 7 clocks later; winner_oh=01, idx=0, tie=0, armed=0.
- Both buttons rise on the same clock → push once, winner_oh=11, idx=0, tie=1. With TIE_PRIORITY_EN: winner_oh=01, tie=0.
- pb[1] wins; then pb[0] pressed in DECIDED → no push, outputs unchanged. clr while pb[1] still held → stays REARM until release; then armed=1. A new pb[0] press wins with idx=0.
- Bounce pb[0] high for 2 clocks then low (DEB=4) → no push; winner_oh stays 0.
- clr asserted in the same cycle as a press event in ARMED → no push, FSM goes to REARM.
- N=4, IDX_W=2: pb[3] first → winner_idx=3, winner_oh=1000. Assert rst low mid-round → all outputs 0 asynchronously, armed=0.
